// File: rtl/dec_pipe_if.sv
// Handshake bundle for dec_pipe: code input side, decoded output side,
// and the zero-code statistic.
interface dec_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [7:0] zero_cnt;

    // Upstream/downstream environment side
    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_a, zero_cnt
    );

    // Decoder side
    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_a, zero_cnt
    );
endinterface

// File: rtl/dec_pipe.sv
// Priority-code to one-hot decoder with a 2-entry output FIFO and a
// saturating count of accepted "no bit set" codes.
//
// state | meaning
// EMPTY | no stored entry, out_valid low
// ONE   | one entry at read pointer, can still accept
// FULL  | two entries, in_ready low until a pop
module dec_pipe (
    input  logic       clk,
    input  logic       rst_n,
    dec_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t       state_q;
    occ_t       state_d;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [7:0] zero_cnt_q;
    logic [3:0] mem [0:1];
    logic       push;
    logic       pop;
    logic [3:0] dec_val;

    // Decode the incoming code; idx is don't-care when v=0
    always_comb begin
        dec_val = 4'b0000;
        if (bus.in_y[2]) begin
            dec_val = 4'b0001 << bus.in_y[1:0];
        end
    end

    // Handshake outputs and occupancy next-state
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = (state_q != FULL) && rst_n;
        bus.out_valid = (state_q != EMPTY);
        bus.out_a     = bus.out_valid ? mem[rd_ptr_q] : 4'b0000;
        bus.zero_cnt  = zero_cnt_q;
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Read/write pointers toggle on pop/push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage is data-only; validity comes from occupancy, so no reset
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= dec_val;
        end
    end

    // Saturating count of accepted v=0 codes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_cnt_q <= 8'h00;
        end else if (push && !bus.in_y[2] && (zero_cnt_q != 8'hFF)) begin
            zero_cnt_q <= zero_cnt_q + 8'h01;
        end
    end

endmodule

// File: doc/dec_pipe.md
DEC_PIPE -- requirements
Module: dec_pipe

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk        input   1  single clock; all state updates on rising edge
  rst_n      input   1  reset, synchronous, active-low
  in_valid   input   1  upstream offers a code this cycle
  in_ready   output  1  block can accept a code this cycle
  in_y       input   3  priority code {v, idx[1:0]}; v=1 means idx is valid, v=0 means no bit set
  out_valid  output  1  decoded value available on out_a
  out_ready  input   1  downstream accepts out_a this cycle
  out_a      output  4  decoded one-hot value at FIFO head
  zero_cnt   output  8  count of accepted codes with v=0, saturating
REQ-002 The block SHALL have one clock, clk, and one reset, rst_n; rst_n SHALL be synchronous and active-low.
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 Decode rule SHALL be: v=0 -> 4'b0000; v=1 -> one-hot 4'b0001 << idx (idx 0..3 -> 0001, 0010, 0100, 1000).
REQ-005 Decoded values SHALL be held in a 2-entry FIFO with a write pointer, a read pointer and a 2-bit occupancy count.
REQ-006 Occupancy SHALL move between states EMPTY(0), ONE(1) and FULL(2); no other value is legal.
REQ-007 in_ready SHALL be 1 when occupancy < 2 and rst_n=1, and 0 otherwise; it SHALL be combinational from registered state.
REQ-008 Push SHALL occur when in_valid and in_ready are both 1; the decoded in_y is written at the write pointer, and the write pointer then toggles.
REQ-009 out_valid SHALL be 1 exactly when occupancy != 0.
REQ-010 out_a SHALL equal the entry at the read pointer when out_valid=1, and 4'b0000 when out_valid=0.
REQ-011 Pop SHALL occur when out_valid and out_ready are both 1; the read pointer then toggles.
REQ-012 Latency SHALL be 1 cycle: a code pushed at edge N into an EMPTY FIFO is visible on out_a/out_valid after edge N; there is no combinational in->out bypass.
REQ-013 Simultaneous push and pop in state ONE SHALL leave occupancy at 1, with the new entry becoming head after the pop.
REQ-014 In state FULL, in_ready=0, so a pop SHALL reduce occupancy to 1 with no push that cycle.
REQ-015 Pop with out_ready=1 in state EMPTY SHALL have no effect.
REQ-016 out_a and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 zero_cnt SHALL increment by 1 on each push with in_y[2]=0, saturate at 8'hFF, and never wrap.
REQ-018 in_y[1:0] SHALL be ignored when in_y[2]=0.

Reset
REQ-019 While rst_n=0 at a rising edge, the block SHALL clear occupancy, both pointers and zero_cnt to 0, and SHALL push or pop nothing.
REQ-020 After reset, out_valid=0, out_a=4'b0000, zero_cnt=8'h00, and in_ready=1 from the first cycle with rst_n=1.
REQ-021 Reset asserted mid-operation (FIFO ONE or FULL) SHALL discard all stored entries at that edge, regardless of the handshake inputs.
REQ-022 FIFO storage contents SHALL NOT require reset; only the control state is reset.

Verification
REQ-023 Single-code scenario: after reset, push in_y=3'b100, 3'b101, 3'b110, 3'b111 with out_ready=1 -> out_a shows 0001, 0010, 0100, 1000 in order, each 1 cycle after its push.
REQ-024 Zero-code scenario: push in_y=3'b011 -> out_a=0000 with out_valid=1, and zero_cnt increments from 0 to 1.
REQ-025 Backpressure scenario: out_ready=0, push 101 then 110 -> in_ready=0 after the second push, out_a held at 0010; a third push attempt with 111 is not accepted; raising out_ready drains 0010 then 0100.
REQ-026 Concurrent scenario: in state ONE, push 111 and pop in the same cycle -> occupancy stays 1 and the next out_a=1000.
REQ-027 Saturation scenario: push 300 codes with v=0 -> zero_cnt=8'hFF and holds there.
REQ-028 Reset scenario: hold FULL, then pulse rst_n=0 for 1 edge -> out_valid=0, in_ready=1 and zero_cnt=0 at the next cycle.
